driver_sout_readback: RTL
=========================

Name: driver_sout_readback

Overview:
- Passive checker on the LED-driver daisy chains: captures the serial data returned on the drivers' SOUT line while the driver controller shifts, and compares it against the configuration word the controller sent.
- Walks all chains through the external SOUT multiplexer, one chain at a time, and reports a per-chain mismatch mask.
- Sits beside driver_controller in the 33 MHz domain. It observes driver_sclk, selects driver_sout_mux and samples driver_sout.

Parameters:
- CONF_BITS, 48, bits shifted out per chain per readback; MSB arrives first.
- NB_CHAINS, 30, number of driver chains behind the SOUT mux.
- SETTLE_CYCLES, 4, clk_33 cycles to wait after changing the mux before sampling begins.
- TIMEOUT_CYCLES, 4096, maximum clk_33 cycles between consecutive sclk rising edges during capture.
- MUX_W (localparam), $clog2(NB_CHAINS), width of the mux select.

Ports:
- clk_33  in  1  33 MHz system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a readback sweep.
- expected  in  CONF_BITS  reference word; latched on an accepted start.
- driver_sclk  in  1  driver shift clock as generated by driver_controller; synchronous to clk_33.
- driver_sout  in  1  muxed SOUT from the driver chains.
- driver_sout_mux  out  MUX_W  chain select.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sweep ends.
- error  out  1  OR of error_mask; held until the next start.
- timeout  out  1  sweep aborted on timeout; held until the next start.
- error_mask  out  NB_CHAINS  bit i set means chain i mismatched or timed out.

Behaviour:
- Reset values: driver_sout_mux=0, busy=0, done=0, error=0, timeout=0, error_mask=0. Internal shift register, counters and expected latch are cleared. State = IDLE.
- Reset asserted mid-sweep: the block returns to IDLE on the next edge with all outputs at their reset values. No done pulse is produced.
- Edge detect: sclk_q is registered every cycle regardless of state. A rise is driver_sclk & ~sclk_q. On a rise cycle, driver_sout is sampled in that same cycle.
- IDLE:
  - start=1 → latch expected; clear error_mask, error and timeout; chain=0; driver_sout_mux=0; go to ARM.
  - start is ignored in every other state.
- ARM:
  - Count SETTLE_CYCLES cycles; sclk rises during this period are ignored.
  - Then go to CAPTURE with bit counter=0 and timer=0.
  - An sclk already high on entry to CAPTURE is not treated as an edge.
- CAPTURE:
  - On each rise: shift <= {shift[CONF_BITS-2:0], driver_sout}; bit counter +1; timer=0.
  - Otherwise timer +1.
  - When the CONF_BITS-th bit is taken → CHECK.
  - If timer reaches TIMEOUT_CYCLES → set error_mask[chain] and timeout; go to DONE (no further chains are checked).
- CHECK (one cycle):
  - error_mask[chain] <= (shift != expected_latched).
  - If chain == NB_CHAINS-1 → DONE.
  - Otherwise chain+1, update driver_sout_mux, go to ARM.
- DONE (one cycle):
  - done=1; error <= |error_mask (including the bit written this sweep); busy deasserts; return to IDLE.
  - driver_sout_mux holds its last value until the next start.
- busy = (state != IDLE).
- Latency with no timeout: NB_CHAINS×(SETTLE_CYCLES + capture time + 1) + 1 cycles from start to done.
- Extra sclk rises between the CHECK and ARM states are ignored.
- The bit counter never wraps; it is reset on every entry to CAPTURE.

Optional Feature:
- Macro: DRIVER_SOUT_READBACK_CAPTURE_EN.
- Defined:
  - Adds output port captured (CONF_BITS), reset to 0.
  - captured is loaded with the shift register in every CHECK cycle, so after done it holds the last fully captured chain's word.
  - On a timeout it keeps the previous value.
- Undefined: the port and its register do not exist; behaviour is otherwise identical.

Test Plan:
- Match: expected=48'hA5A5_0F0F_1234; the bench model returns that word on every chain for 48 rises per chain → single done pulse, error=0, timeout=0, error_mask=0, driver_sout_mux=29 at done.
- Single mismatch: chain 3 returns 48'hA5A5_0F0F_1235 → error_mask=30'h0000_0008, error=1, timeout=0.
- Timeout: TIMEOUT_CYCLES=1000; sclk stops after 10 bits on chain 0 → timeout=1 and error_mask=1 exactly 1000 cycles after the last rise, done pulse next cycle, driver_sout_mux=0.
- Settle filter: 3 sclk rises with sout=1 injected during ARM, then a correct 48-bit word → error_mask bit clear for that chain.
- Handshake and reset: a second start while busy is ignored (expected is not relatched, no extra done). rst asserted at bit 20 of chain 5 → busy=0 and error_mask=0 next cycle, no done. A new start then completes normally.
- With DRIVER_SOUT_READBACK_CAPTURE_EN defined: captured equals chain 29's returned word (48'h0000_DEAD_BEEF) at done.

Source files
------------

// File: rtl/driver_sout_readback.sv
// Passive SOUT readback checker: walks every driver chain through the SOUT mux and flags mismatches.
// Optional `captured` output enabled by DRIVER_SOUT_READBACK_CAPTURE_EN.
module driver_sout_readback #(
  parameter  int unsigned CONF_BITS      = 48,
  parameter  int unsigned NB_CHAINS      = 30,
  parameter  int unsigned SETTLE_CYCLES  = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned MUX_W          = $clog2(NB_CHAINS)
) (
  input  logic                 clk_33,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CONF_BITS-1:0] expected,
  input  logic                 driver_sclk,
  input  logic                 driver_sout,
  output logic [MUX_W-1:0]     driver_sout_mux,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 timeout,
  output logic [NB_CHAINS-1:0] error_mask
`ifdef DRIVER_SOUT_READBACK_CAPTURE_EN
  ,
  output logic [CONF_BITS-1:0] captured
`endif
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned BIT_W = $clog2(CONF_BITS + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic                 r_sclk_q;
  logic [CONF_BITS-1:0] r_expected;
  logic [CONF_BITS-1:0] r_shift;
  logic [SET_W-1:0]     r_settle;
  logic [BIT_W-1:0]     r_bits;
  logic [TMR_W-1:0]     r_timer;
  logic [MUX_W-1:0]     r_mux;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic                 r_timeout;
  logic [NB_CHAINS-1:0] r_mask;
`ifdef DRIVER_SOUT_READBACK_CAPTURE_EN
  logic [CONF_BITS-1:0] r_captured;
`endif

  logic                 w_rise;
  logic [NB_CHAINS-1:0] w_chain_bit;

  assign w_rise      = driver_sclk & ~r_sclk_q;
  assign w_chain_bit = NB_CHAINS'(1) << r_mux;

  // Edge-detect history runs in every state, including reset.
  always_ff @(posedge clk_33) begin
    r_sclk_q <= driver_sclk;
  end

  always_ff @(posedge clk_33) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_expected <= '0;
      r_shift    <= '0;
      r_settle   <= '0;
      r_bits     <= '0;
      r_timer    <= '0;
      r_mux      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
      r_mask     <= '0;
`ifdef DRIVER_SOUT_READBACK_CAPTURE_EN
      r_captured <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_expected <= expected;
            r_mask     <= '0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
            r_mux      <= '0;
            r_settle   <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          // Mux settling time; any sclk activity here is deliberately ignored.
          if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
            r_settle <= '0;
            r_bits   <= '0;
            r_timer  <= '0;
            r_state  <= ST_CAPTURE;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (w_rise) begin
            r_shift <= {r_shift[CONF_BITS-2:0], driver_sout};
            r_bits  <= r_bits + BIT_W'(1);
            r_timer <= '0;
            if (r_bits == BIT_W'(CONF_BITS - 1)) begin
              r_state <= ST_CHECK;
            end
          end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            r_mask    <= r_mask | w_chain_bit;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_CHECK: begin
          r_mask <= (r_shift != r_expected) ? (r_mask | w_chain_bit) : (r_mask & ~w_chain_bit);
`ifdef DRIVER_SOUT_READBACK_CAPTURE_EN
          r_captured <= r_shift;
`endif
          if (r_mux == MUX_W'(NB_CHAINS - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_mux    <= r_mux + MUX_W'(1);
            r_settle <= '0;
            r_state  <= ST_ARM;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_error <= |r_mask;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign driver_sout_mux = r_mux;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign timeout         = r_timeout;
  assign error_mask      = r_mask;
`ifdef DRIVER_SOUT_READBACK_CAPTURE_EN
  assign captured        = r_captured;
`endif

endmodule
